pkt_rx_checker: RTL

PKT_RX_CHECKER -- requirements
Module: pkt_rx_checker

---
 rtl/pkt_rx_if.sv | 29 ++
 rtl/pkt_rx_checker.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pkt_rx_if.sv
// Byte-stream bus between the router output and the packet checker,
// carrying the checker's forwarded payload, status and counters.
interface pkt_rx_if;
    logic [7:0]  dut_outp;
    logic        outp_valid;
    logic [7:0]  pl_data;
    logic        pl_valid;
    logic        pl_last;
    logic        status_valid;
    logic [2:0]  status;
    logic [7:0]  pkt_sa;
    logic [7:0]  pkt_da;
    logic [31:0] pkt_len;
    logic        ovr_pulse;
    logic [15:0] pkt_count;
    logic [15:0] err_count;

    modport master (
        output dut_outp, outp_valid,
        input  pl_data, pl_valid, pl_last, status_valid, status,
        input  pkt_sa, pkt_da, pkt_len, ovr_pulse, pkt_count, err_count
    );

    modport slave (
        input  dut_outp, outp_valid,
        output pl_data, pl_valid, pl_last, status_valid, status,
        output pkt_sa, pkt_da, pkt_len, ovr_pulse, pkt_count, err_count
    );
endinterface

// File: rtl/pkt_rx_checker.sv
// Receives router packets (sa, da, len, crc, payload), forwards the payload,
// and reports per-packet status, header fields and good/error counters.
module pkt_rx_checker #(
    parameter int unsigned MIN_LEN = 12,
    parameter int unsigned MAX_LEN = 1024
) (
    input  logic     clk,
    input  logic     reset,
    pkt_rx_if.slave  bus
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_HDR     = 2'd1;
    localparam logic [1:0] S_PAYLOAD = 2'd2;
    localparam logic [1:0] S_DRAIN   = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] sum_q, sum_d;
    logic [7:0]  sa_q, sa_d, da_q, da_d;
    logic [31:0] len_q, len_d, crc_q, crc_d;
    logic        last_q, last_d;
    logic        fresh_q, fresh_d;
    logic [7:0]  pl_data_q, pl_data_d;
    logic        pl_valid_q, pl_valid_d, pl_last_q, pl_last_d;
    logic        stat_vld_q, stat_vld_d;
    logic [2:0]  stat_q, stat_d;
    logic [7:0]  out_sa_q, out_sa_d, out_da_q, out_da_d;
    logic [31:0] out_len_q, out_len_d;
    logic        ovr_q, ovr_d;
    logic [15:0] pkt_cnt_q, pkt_cnt_d, err_cnt_q, err_cnt_d;

    logic [31:0] len_full, crc_full;
    logic [1:0]  pkt_inc, err_inc;

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] inc);
        logic [16:0] s;
        s = {1'b0, a} + {15'd0, inc};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    // Field values including the byte being sampled right now.
    assign len_full = {bus.dut_outp, len_q[23:0]};
    assign crc_full = {bus.dut_outp, crc_q[23:0]};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sum_d      = sum_q;
        sa_d       = sa_q;
        da_d       = da_q;
        len_d      = len_q;
        crc_d      = crc_q;
        last_d     = 1'b0;
        fresh_d    = 1'b0;
        pl_data_d  = pl_data_q;
        pl_valid_d = 1'b0;
        pl_last_d  = 1'b0;
        stat_vld_d = 1'b0;
        stat_d     = stat_q;
        ovr_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.outp_valid) begin
                    // A byte right after completion or reset release is not a new packet.
                    if (last_q || fresh_q) begin
                        state_d = S_DRAIN;
                        ovr_d   = last_q;
                    end else begin
                        state_d = S_HDR;
                        cnt_d   = 32'd1;
                        sum_d   = 32'd0;
                        sa_d    = bus.dut_outp;
                        da_d    = 8'd0;
                        len_d   = 32'd0;
                        crc_d   = 32'd0;
                    end
                end
            end
            S_HDR: begin
                if (!bus.outp_valid) begin
                    stat_vld_d = 1'b1;
                    stat_d     = 3'd4;
                    state_d    = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                    case (cnt_q)
                        32'd1: da_d = bus.dut_outp;
                        32'd2: len_d[7:0]   = bus.dut_outp;
                        32'd3: len_d[15:8]  = bus.dut_outp;
                        32'd4: len_d[23:16] = bus.dut_outp;
                        32'd5: begin
                            len_d = len_full;
                            if (len_full < MIN_LEN) begin
                                stat_vld_d = 1'b1;
                                stat_d     = 3'd2;
                                state_d    = S_DRAIN;
                            end else if (len_full > MAX_LEN) begin
                                stat_vld_d = 1'b1;
                                stat_d     = 3'd3;
                                state_d    = S_DRAIN;
                            end
                        end
                        32'd6: crc_d[7:0]   = bus.dut_outp;
                        32'd7: crc_d[15:8]  = bus.dut_outp;
                        32'd8: crc_d[23:16] = bus.dut_outp;
                        32'd9: begin
                            crc_d = crc_full;
                            // Header-only packet is possible only when MIN_LEN <= 10.
                            if (len_q == 32'd10) begin
                                stat_vld_d = 1'b1;
                                stat_d     = (crc_full == 32'd0) ? 3'd0 : 3'd1;
                                state_d    = S_IDLE;
                                last_d     = 1'b1;
                            end else begin
                                state_d = S_PAYLOAD;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_PAYLOAD: begin
                if (!bus.outp_valid) begin
                    stat_vld_d = 1'b1;
                    stat_d     = 3'd4;
                    state_d    = S_IDLE;
                end else begin
                    cnt_d      = cnt_q + 32'd1;
                    sum_d      = sum_q + {24'd0, bus.dut_outp};
                    pl_valid_d = 1'b1;
                    pl_data_d  = bus.dut_outp;
                    if (cnt_d == len_q) begin
                        pl_last_d  = 1'b1;
                        stat_vld_d = 1'b1;
                        stat_d     = (sum_d == crc_q) ? 3'd0 : 3'd1;
                        state_d    = S_IDLE;
                        last_d     = 1'b1;
                    end
                end
            end
            default: begin
                if (!bus.outp_valid) state_d = S_IDLE;
            end
        endcase

        out_sa_d  = stat_vld_d ? sa_d  : out_sa_q;
        out_da_d  = stat_vld_d ? da_d  : out_da_q;
        out_len_d = stat_vld_d ? len_d : out_len_q;

        pkt_inc   = {1'b0, stat_vld_d && (stat_d == 3'd0)};
        err_inc   = {1'b0, stat_vld_d && (stat_d != 3'd0)} + {1'b0, ovr_d};
        pkt_cnt_d = sat_add(pkt_cnt_q, pkt_inc);
        err_cnt_d = sat_add(err_cnt_q, err_inc);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 32'd0;
            sum_q      <= 32'd0;
            sa_q       <= 8'd0;
            da_q       <= 8'd0;
            len_q      <= 32'd0;
            crc_q      <= 32'd0;
            last_q     <= 1'b0;
            fresh_q    <= 1'b1;
            pl_data_q  <= 8'd0;
            pl_valid_q <= 1'b0;
            pl_last_q  <= 1'b0;
            stat_vld_q <= 1'b0;
            stat_q     <= 3'd0;
            out_sa_q   <= 8'd0;
            out_da_q   <= 8'd0;
            out_len_q  <= 32'd0;
            ovr_q      <= 1'b0;
            pkt_cnt_q  <= 16'd0;
            err_cnt_q  <= 16'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sum_q      <= sum_d;
            sa_q       <= sa_d;
            da_q       <= da_d;
            len_q      <= len_d;
            crc_q      <= crc_d;
            last_q     <= last_d;
            fresh_q    <= fresh_d;
            pl_data_q  <= pl_data_d;
            pl_valid_q <= pl_valid_d;
            pl_last_q  <= pl_last_d;
            stat_vld_q <= stat_vld_d;
            stat_q     <= stat_d;
            out_sa_q   <= out_sa_d;
            out_da_q   <= out_da_d;
            out_len_q  <= out_len_d;
            ovr_q      <= ovr_d;
            pkt_cnt_q  <= pkt_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign bus.pl_data      = pl_data_q;
    assign bus.pl_valid     = pl_valid_q;
    assign bus.pl_last      = pl_last_q;
    assign bus.status_valid = stat_vld_q;
    assign bus.status       = stat_q;
    assign bus.pkt_sa       = out_sa_q;
    assign bus.pkt_da       = out_da_q;
    assign bus.pkt_len      = out_len_q;
    assign bus.ovr_pulse    = ovr_q;
    assign bus.pkt_count    = pkt_cnt_q;
    assign bus.err_count    = err_cnt_q;
endmodule
